// File: rtl/avalon_st_pkg.sv
// Shared definitions for the Avalon-ST retiming stage: width helpers and
// the packet-framing monitor state encoding.
package avalon_st_pkg;

  function automatic int log2up(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Width of the empty field for a beat of the given symbol count.
  function automatic int empty_width(input int bytes_per_beat);
    return log2up(bytes_per_beat);
  endfunction

  localparam int DEFAULT_BYTES = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

endpackage

// File: rtl/avalon_st_modport_stage_if.sv
// Avalon-ST source-side and sink-side signals of one retiming stage.
// master = the surrounding logic (source and sink), slave = the stage itself.
interface avalon_st_modport_stage_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = avalon_st_pkg::empty_width(DATA_WIDTH_IN_BYTES);

  logic [DATA_W-1:0]  in_data;
  logic [EMPTY_W-1:0] in_empty;
  logic               in_valid;
  logic               in_sop;
  logic               in_eop;
  logic               in_rdy;

  logic [DATA_W-1:0]  out_data;
  logic [EMPTY_W-1:0] out_empty;
  logic               out_valid;
  logic               out_sop;
  logic               out_eop;
  logic               out_rdy;

  modport master (
    output in_data, in_empty, in_valid, in_sop, in_eop,
    input  in_rdy,
    input  out_data, out_empty, out_valid, out_sop, out_eop,
    output out_rdy
  );

  modport slave (
    input  in_data, in_empty, in_valid, in_sop, in_eop,
    output in_rdy,
    output out_data, out_empty, out_valid, out_sop, out_eop,
    input  out_rdy
  );

endinterface

// File: rtl/avalon_st_skid_reg.sv
// Generic valid/ready skid register: one output register plus one skid slot.
// Ready toward the source comes straight from a flop, so no comb path crosses.
module avalon_st_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_payload,
  input  logic             in_valid,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_payload,
  output logic             out_valid,
  input  logic             out_rdy
);
  logic [WIDTH-1:0] payload_p0;
  logic             vld_p0;
  logic             vld_p0_nxt;
  logic [WIDTH-1:0] payload_p1;
  logic             vld_p1;
  logic             accept;
  logic             out_free;

  assign accept   = in_valid & in_rdy;
  assign out_free = ~vld_p1 | out_rdy;
  assign in_rdy   = ~vld_p0;

  always_comb begin
    vld_p0_nxt = vld_p0;
    if (out_free)    vld_p0_nxt = 1'b0;
    else if (accept) vld_p0_nxt = 1'b1;
  end

  // p0: skid slot, loaded only when the output register is stalled
  always_ff @(posedge clk) begin
    if (!out_free && accept) payload_p0 <= in_payload;
  end

  // p1: output register, refilled from the skid slot before new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      payload_p1 <= '0;
    end else begin
      vld_p0 <= vld_p0_nxt;
      if (out_free) begin
        if (vld_p0) begin
          vld_p1     <= 1'b1;
          payload_p1 <= payload_p0;
        end else begin
          vld_p1 <= accept;
          if (accept) payload_p1 <= in_payload;
        end
      end
    end
  end

  assign out_payload = payload_p1;
  assign out_valid   = vld_p1;

endmodule

// File: rtl/avalon_st_modport_stage.sv
// Registered Avalon-ST stage with packet-framing monitor: framing error pulse,
// saturating error count and wrapping packet count, all driven by accepted beats.
module avalon_st_modport_stage
  import avalon_st_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  avalon_st_modport_stage_if.slave st,
  output logic                     in_pkt_active,
  output logic                     err_framing,
  output logic [7:0]               err_count,
  output logic [15:0]              pkt_count
);
  localparam int DATA_W    = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W   = empty_width(DATA_WIDTH_IN_BYTES);
  localparam int PAYLOAD_W = DATA_W + EMPTY_W + 2;

  logic [PAYLOAD_W-1:0] payload_in;
  logic [PAYLOAD_W-1:0] payload_out;
  logic [EMPTY_W-1:0]   empty_masked;
  logic                 rdy;
  logic                 out_vld;
  logic                 accept;
  frame_state_e         state;
  frame_state_e         state_nxt;
  logic                 err_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Empty is only meaningful on eop, so it is cleaned before it enters the pipe.
  assign empty_masked = st.in_eop ? st.in_empty : '0;
  assign payload_in   = {st.in_data, empty_masked, st.in_sop, st.in_eop};
  assign accept       = st.in_valid & rdy;

  avalon_st_skid_reg #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_payload  (payload_in),
    .in_valid    (st.in_valid),
    .in_rdy      (rdy),
    .out_payload (payload_out),
    .out_valid   (out_vld),
    .out_rdy     (st.out_rdy)
  );

  assign st.in_rdy    = rdy;
  assign st.out_valid = out_vld;
  assign {st.out_data, st.out_empty, st.out_sop, st.out_eop} = payload_out;

  // Every accepted beat ends up in IN_PKT unless it carries eop; an errored
  // beat is simply treated as the start of a fresh packet.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    if (accept) begin
      err_nxt   = (state == ST_IDLE) ? ~st.in_sop : st.in_sop;
      state_nxt = st.in_eop ? ST_IDLE : ST_IN_PKT;
    end
  end

  // p1: framing state and monitor outputs, registered on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      err_framing <= 1'b0;
      err_count   <= 8'd0;
      pkt_count   <= 16'd0;
    end else begin
      state       <= state_nxt;
      err_framing <= err_nxt;
      if (err_nxt)             err_count <= sat_inc8(err_count);
      if (accept && st.in_eop) pkt_count <= pkt_count + 16'd1;
    end
  end

  assign in_pkt_active = (state == ST_IN_PKT);

endmodule

// File: tb/tb_avalon_st_modport_stage.sv
// Bench for avalon_st_modport_stage: vector table, backpressure and reset
// sequences, with a scoreboard queue tracking every beat through the stage.
module tb_avalon_st_modport_stage;
  localparam int DW = 32;
  localparam int EW = 2;

  logic        clk;
  logic        rst_n;
  logic        in_pkt_active;
  logic        err_framing;
  logic [7:0]  err_count;
  logic [15:0] pkt_count;

  avalon_st_modport_stage_if #(.DATA_WIDTH_IN_BYTES(4)) st_if ();

  avalon_st_modport_stage #(.DATA_WIDTH_IN_BYTES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st            (st_if),
    .in_pkt_active (in_pkt_active),
    .err_framing   (err_framing),
    .err_count     (err_count),
    .pkt_count     (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [EW-1:0] in_empty;
    logic [EW-1:0] exp_empty;
    logic [DW-1:0] data;
    logic          exp_err;
    logic          exp_active;
  } vec_t;

  beat_t sb_q[$];
  beat_t mon_e;
  beat_t mon_p;
  vec_t  tbl[20];
  int    checks = 0;
  int    errors = 0;
  int    exp_errc;
  int    exp_pkt;
  time   last_acc_t;
  time   t4;
  time   t6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic send_beat(input logic sop, input logic eop, input logic [EW-1:0] empty,
                           input logic [DW-1:0] data);
    bit got;
    got = 1'b0;
    st_if.in_valid = 1'b1;
    st_if.in_sop   = sop;
    st_if.in_eop   = eop;
    st_if.in_empty = empty;
    st_if.in_data  = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (st_if.in_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      last_acc_t = $time;
      #1;
      if (eop) exp_pkt = exp_pkt + 1;
      st_if.in_valid = 1'b0;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat 0x%0h not accepted within 50 cycles", data);
      st_if.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int sat255(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Scoreboard: handshakes are evaluated half a cycle before the edge they complete on.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (st_if.out_valid && st_if.out_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got beat 0x%0h, expected no beat", st_if.out_data);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_data", st_if.out_data, mon_e.data);
          chk("sb_ctrl", {28'd0, st_if.out_empty, st_if.out_sop, st_if.out_eop},
              {28'd0, mon_e.empty, mon_e.sop, mon_e.eop});
        end
      end
      if (st_if.in_valid && st_if.in_rdy) begin
        mon_p.data  = st_if.in_data;
        mon_p.empty = st_if.in_eop ? st_if.in_empty : 2'd0;
        mon_p.sop   = st_if.in_sop;
        mon_p.eop   = st_if.in_eop;
        sb_q.push_back(mon_p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming packet; non-eop beats drive a nonzero empty that must be dropped.
    tbl[0]  = '{1'b1, 1'b0, 2'd3, 2'd0, 32'h11111111, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 2'd3, 2'd0, 32'h22222222, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 2'd1, 2'd0, 32'h33333333, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 2'd2, 32'h44444444, 1'b0, 1'b0};
    for (int i = 4; i < 14; i++)
      tbl[i] = '{1'b1, 1'b1, 2'd1, 2'd1, 32'hA0000000 + 32'(i), 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 2'd0, 32'hC0000001, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 2'd0, 32'hC0000002, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 2'd0, 32'hC0000003, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 2'd2, 2'd2, 32'hC0000004, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 2'd0, 2'd0, 32'hC0000005, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 2'd3, 2'd3, 32'hC0000006, 1'b0, 1'b0};

    exp_errc = 0;
    exp_pkt  = 0;
    st_if.in_valid = 1'b0;
    st_if.in_sop   = 1'b0;
    st_if.in_eop   = 1'b0;
    st_if.in_empty = '0;
    st_if.in_data  = '0;
    st_if.out_rdy  = 1'b1;
    rst_n = 1'b0;

    #12;
    chk("rst_out_valid", st_if.out_valid, 0);
    chk("rst_in_rdy", st_if.in_rdy, 1);
    chk("rst_out_data", st_if.out_data, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err_framing", err_framing, 0);
    chk("rst_pkt_active", in_pkt_active, 0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    st_if.in_sop  = 1'b1;
    st_if.in_eop  = 1'b1;
    st_if.in_data = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", st_if.out_valid, 0);
    chk("idle_out_data", st_if.out_data, 0);
    chk("idle_pkt_count", pkt_count, 0);
    chk("idle_err_framing", err_framing, 0);

    for (int i = 0; i < 20; i++) begin
      send_beat(tbl[i].sop, tbl[i].eop, tbl[i].in_empty, tbl[i].data);
      if (tbl[i].exp_err) exp_errc = sat255(exp_errc);
      chk("vec_err_framing", err_framing, tbl[i].exp_err);
      chk("vec_pkt_active", in_pkt_active, tbl[i].exp_active);
      chk("vec_out_valid", st_if.out_valid, 1);
      chk("vec_out_data", st_if.out_data, tbl[i].data);
      chk("vec_out_empty", st_if.out_empty, tbl[i].exp_empty);
      chk("vec_err_count", err_count, exp_errc);
      chk("vec_pkt_count", pkt_count, exp_pkt);
    end

    // Backpressure: three stalled cycles starting just after beat 2 is presented.
    fork
      begin
        send_beat(1'b1, 1'b0, 2'd0, 32'hB0000001);
        send_beat(1'b0, 1'b0, 2'd0, 32'hB0000002);
        send_beat(1'b0, 1'b0, 2'd0, 32'hB0000003);
        send_beat(1'b0, 1'b0, 2'd0, 32'hB0000004);
        t4 = last_acc_t;
        send_beat(1'b0, 1'b0, 2'd0, 32'hB0000005);
        send_beat(1'b0, 1'b1, 2'd1, 32'hB0000006);
        t6 = last_acc_t;
      end
      begin
        repeat (2) @(posedge clk);
        #1 st_if.out_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_in_rdy_low", st_if.in_rdy, 0);
        chk("bp_hold_data", st_if.out_data, 32'hB0000002);
        @(posedge clk);
        #1;
        chk("bp_stable_data", st_if.out_data, 32'hB0000002);
        chk("bp_stable_valid", st_if.out_valid, 1);
        @(posedge clk);
        #1 st_if.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_rdy_back", st_if.in_rdy, 1);
        chk("bp_skid_to_out", st_if.out_data, 32'hB0000003);
      end
    join
    chk("bp_throughput", 32'(t6 - t4), 20);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", sb_q.size(), 0);
    chk("bp_pkt_count", pkt_count, exp_pkt);
    chk("bp_err_count", err_count, exp_errc);

    for (int i = 0; i < 300; i++) begin
      send_beat(1'b0, 1'b1, 2'd0, 32'hE0000000 + 32'(i));
      exp_errc = sat255(exp_errc);
    end
    chk("sat_err_count", err_count, 255);
    chk("sat_err_framing", err_framing, 1);
    chk("sat_pkt_count", pkt_count, exp_pkt);

    // Reset in the middle of a packet, asserted between clock edges.
    send_beat(1'b1, 1'b0, 2'd0, 32'hD0000001);
    send_beat(1'b0, 1'b0, 2'd0, 32'hD0000002);
    #2 rst_n = 1'b0;
    #1;
    exp_errc = 0;
    exp_pkt  = 0;
    chk("mrst_out_valid", st_if.out_valid, 0);
    chk("mrst_out_data", st_if.out_data, 0);
    chk("mrst_in_rdy", st_if.in_rdy, 1);
    chk("mrst_pkt_active", in_pkt_active, 0);
    chk("mrst_err_count", err_count, 0);
    chk("mrst_pkt_count", pkt_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_beat(1'b0, 1'b0, 2'd0, 32'hD0000003);
    chk("mrst_first_err", err_framing, 1);
    chk("mrst_first_errc", err_count, 1);
    chk("mrst_first_active", in_pkt_active, 1);
    send_beat(1'b0, 1'b1, 2'd1, 32'hD0000004);
    chk("mrst_close_err", err_framing, 0);
    chk("mrst_close_pkt", pkt_count, exp_pkt);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_st_modport_stage.md
Name: avalon_st_modport_stage

Overview:
- Registered Avalon-ST pipeline stage (skid buffer) between an upstream source and a downstream sink.
- Breaks the combinational valid/ready path in both directions while sustaining one beat per cycle.
- Adds packet-framing monitoring: framing error pulse, saturating error count, packet count.
- Used wherever an Avalon-ST link needs retiming, e.g. ahead of header-insertion logic.

Parameters:
- DATA_WIDTH_IN_BYTES, 4, symbols (bytes) per beat; data width = 8*DATA_WIDTH_IN_BYTES.
- EMPTY_W, max(1, ceil(log2(DATA_WIDTH_IN_BYTES))), width of the empty field; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8*DATA_WIDTH_IN_BYTES  upstream beat data.
- in_empty  in  EMPTY_W  unused byte count; meaningful on eop only.
- in_valid  in  1  upstream beat valid.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_rdy  out  1  stage can accept a beat (registered).
- out_data  out  8*DATA_WIDTH_IN_BYTES  downstream beat data.
- out_empty  out  EMPTY_W  downstream empty.
- out_valid  out  1  downstream beat valid.
- out_sop  out  1  downstream start of packet.
- out_eop  out  1  downstream end of packet.
- out_rdy  in  1  downstream ready.
- in_pkt_active  out  1  input framing FSM is inside a packet.
- err_framing  out  1  one-cycle pulse on an accepted beat that violates framing.
- err_count  out  8  saturating count of framing errors.
- pkt_count  out  16  wrapping count of accepted eop beats.

Behaviour:
- Interface: reset is asynchronous and active-low (rst_n). The single clock is clk.
- Handshake: ready latency 0. A transfer occurs in a cycle where valid and rdy are both 1 at the clock edge. out_* hold stable while out_valid=1 and out_rdy=0.
- Storage: one output register plus one skid register.
- in_rdy is registered. in_rdy = 1 exactly when the skid register is empty.
- Latency: an accepted beat appears on out_* the next cycle if the output register is free.
- Throughput: with out_rdy held at 1, one beat per cycle, no bubbles.
- Backpressure: if out_rdy=0 while out_valid=1 and a beat is accepted, the beat goes to the skid register and in_rdy drops the next cycle. When the output drains, the skid beat moves to the output and in_rdy returns to 1.
- Ordering: beats leave in arrival order and are never dropped or duplicated.
- Simultaneous events: an accept and an output pop in the same cycle leave the occupancy unchanged.
- Field passthrough: data, sop and eop pass through unchanged. out_empty equals in_empty on eop beats and is forced to 0 on non-eop beats.
- Invalid beats: in_valid=0 beats are ignored regardless of the other inputs.
- Framing FSM states: IDLE and IN_PKT, updated on accepted beats only.
  - IDLE, sop & !eop -> IN_PKT.
  - IDLE, sop & eop -> IDLE (single-beat packet).
  - IDLE, !sop -> error; state stays IDLE, or enters IN_PKT if !eop.
  - IN_PKT, eop -> IDLE.
  - IN_PKT, sop -> error (missing eop). The beat is treated as a new packet start: IN_PKT, or IDLE if eop.
- in_pkt_active = (state == IN_PKT).
- Errored beats are still forwarded unchanged.
- err_framing is registered: it asserts the cycle after the offending accept, for one cycle.
- err_count increments per error and saturates at 255.
- pkt_count increments on every accepted eop beat and wraps at 65535 -> 0.
- Reset values: out_valid, out_sop, out_eop, out_data, out_empty = 0; in_rdy = 1; skid empty; FSM IDLE; err_framing = 0; err_count = 0; pkt_count = 0.
- Reset mid-packet: all state and beats in flight are discarded immediately. The first post-reset beat must carry sop, otherwise it is a framing error.

Decomposition:
- Shared package avalon_st_pkg: log2up function, EMPTY_W derivation, framing FSM state enum.
- Natural sub-module: avalon_st_skid_reg, a generic valid/ready skid register carrying the packed {data, empty, sop, eop}.
- Framing monitor and counters live in the top module.

Test Plan:
- Reset then idle: rst_n=0 -> out_valid=0, in_rdy=1, counters 0; after release with in_valid=0, no outputs change.
- Streaming: 4-beat packet, data 0x11111111..0x44444444, empty=2 on eop, out_rdy=1 -> identical beats 1 cycle later, out_empty 0,0,0,2; pkt_count=1; no error.
- Backpressure: out_rdy=0 for 3 cycles mid-stream -> in_rdy falls after one extra accept; no beat lost; order preserved after out_rdy=1; throughput back to 1 beat/cycle.
- Single-beat packets: 10 back-to-back sop&eop beats -> pkt_count=10, in_pkt_active stays 0.
- Framing errors: sop, data, sop (no eop) -> err_framing pulse and err_count=1; then a non-sop beat while IDLE -> err_count=2; 300 errors -> err_count=255.
- Mid-packet reset: assert rst_n=0 after 2 of 4 beats -> outputs cleared asynchronously; next non-sop beat raises err_framing.
